// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch-entry payload carried from IF to the decode boundary.
package rv_fetch_pkg;

    localparam int XLEN = 64;
    localparam int IMEM_AW = 10;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer for fetched {instr, pc} pairs.
// Ports: clk, reset (async, active-high), i_push/i_data write the tail,
// i_pop drops the head, i_flush empties the buffer (wins over push/pop),
// o_head is the head entry, o_count the number of valid entries (0..2).
module fetch_skid_fifo
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;

    logic w_pop;
    logic w_push;

    // Guard against popping empty or pushing into a full buffer
    // that is not being drained this cycle.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches from a 1-cycle synchronous imem and
// delivers a {valid, instr, pc} stream through a 2-entry skid buffer.
// Ports: clk, reset (async, active-high), stall (decode busy),
// redirect_valid/redirect_pc (flush + new target), imem_addr/imem_rdata
// (memory side), if_valid/if_instr/if_pc (decode side).
module instr_fetch_unit #(
    parameter int              XLEN      = rv_fetch_pkg::XLEN,
    parameter int              IMEM_AW   = rv_fetch_pkg::IMEM_AW,
    parameter logic [XLEN-1:0] RESET_PC  = rv_fetch_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [XLEN-1:0]    if_pc
);

    import rv_fetch_pkg::*;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_req_pending;

    logic [1:0]   w_count;
    logic [2:0]   w_occ;
    logic [2:0]   w_limit;
    logic         w_pop;
    logic         w_issue;
    logic         w_push;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    assign if_valid = (w_count != 2'd0);
    assign w_pop    = if_valid & ~stall;

    // Buffered plus in-flight words must stay within the 2 slots,
    // counting the slot freed by this cycle's pop.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_req_pending};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue = ~redirect_valid & (w_occ < w_limit);

    // The in-flight word is squashed by a redirect.
    assign w_push = r_req_pending & ~redirect_valid;

    assign w_push_data.instr = imem_rdata;
    assign w_push_data.pc    = r_req_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_req_pending <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            r_req_pending <= 1'b0;
        end else begin
            r_req_pending <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    assign imem_addr = r_fetch_pc[IMEM_AW+1:2];

    fetch_skid_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign if_instr = if_valid ? w_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? w_head.pc : '0;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage feeding the pipelined core's `instruction` input. Owns the PC, issues word addresses to a synchronous instruction memory (1-cycle read latency) and buffers returned words in a 2-entry skid FIFO.
- The IF/ID boundary sees a steady {valid, instr, pc} stream. The stream honours load-use stalls without losing fetched words, and is flushed and redirected on a taken branch.

Parameters:
- XLEN, 64, PC/data width
- IMEM_AW, 10, instruction memory word-address width (1024 words)
- RESET_PC, 64'h0, PC fetched first after reset
- NOP_INSTR, 32'h00000013, word driven on if_instr when if_valid=0

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  decode cannot accept this cycle (hazard unit)
- redirect_valid  in  1  taken branch / pipeline flush
- redirect_pc  in  XLEN  new fetch target; bits[1:0] ignored (treated as 0)
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]; combinational from fetch_pc
- imem_rdata  in  32  memory word for the address presented in the previous cycle
- if_valid  out  1  FIFO head holds a valid instruction
- if_instr  out  32  FIFO head instruction; NOP_INSTR when if_valid=0
- if_pc  out  XLEN  PC of the FIFO head; 0 when if_valid=0

Behaviour:
Interface rule: single clock; reset is asynchronous and active-high, port names clk and reset.

Reset values:
- fetch_pc=RESET_PC, FIFO count=0, req_pending=0.
- if_valid=0, if_instr=NOP_INSTR, if_pc=0.
- Reset mid-operation discards all buffered and in-flight words immediately.

Pop:
- pop = if_valid & ~stall.
- Head is consumed at the clock edge.

Issue:
- issue = ~redirect_valid & (count + req_pending - pop < 2).
- On issue: req_pending<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN).
- imem_addr wraps naturally with fetch_pc bits.

Return:
- When req_pending=1 and no redirect this cycle, {imem_rdata, req_pc} is pushed to the FIFO tail.
- req_pending clears unless a new issue occurs the same cycle.
- Push and pop in the same cycle are legal at any count.
- The issue rule guarantees a push never occurs at count=2 without a pop.

Throughput:
- Steady state is count=1, pending=1: one instruction per cycle with stall=0.

Stall:
- FIFO holds its head.
- At most 2 words are buffered; issue halts until space is available.
- No word is dropped or duplicated.
- Releasing stall resumes in-order delivery with no bubble if count≥1.

Redirect (priority over stall, pop, push and issue), asserted in cycle N:
- End of N: FIFO cleared, req_pending<=0 (the in-flight word is squashed), fetch_pc<=redirect_pc&~3.
- N+1: issue at the target, if_valid=0.
- N+2: word returns.
- N+3: if_valid=1, if_pc=target.
- A redirect in consecutive cycles: the last one wins.

Latency:
- Reset released before cycle 0: issue RESET_PC in cycle 0, data in cycle 1, if_valid=1 in cycle 2.

FIFO:
- 2 entries, head/tail pointer plus 2-bit count.
- Outputs are registered from the head entry (no combinational path from imem_rdata to if_*).

Decomposition:
- Package rv_fetch_pkg: XLEN, IMEM_AW, NOP_INSTR, RESET_PC defaults, and a packed struct fetch_entry_t {instr[31:0], pc[XLEN-1:0]}.
- One sub-module, fetch_skid_fifo: 2-entry, with push/pop/flush/count, fetch_entry_t payload and asynchronous reset.
- PC, issue and redirect logic stay in instr_fetch_unit.

Test Plan:
- Memory word k = 0x00100093+k; reset released, stall=0 → if_valid rises cycle 2; if_pc = 0,4,8,... with matching words, one per cycle, no gaps.
- stall held 5 cycles once if_pc=0x8 → if_pc/if_instr frozen at 0x8; count ≤2; after release the sequence continues 0xC, 0x10 with no skip or repeat.
- redirect_valid with redirect_pc=0x24 while stall=1 and FIFO full → if_valid=0 for 2 cycles; then if_pc=0x24, 0x28; old words never appear.
- redirect_pc=0x27 → fetch begins at 0x24.
- Back-to-back redirects to 0x40 then 0x80 → first valid pc is 0x80.
- fetch_pc reaches 0xFFC (IMEM_AW=10) → next imem_addr=0 and if_pc=0x1000 (PC not wrapped, address wrapped).
- reset asserted mid-stream with 2 words buffered → if_valid=0 and if_instr=0x00000013 immediately, asynchronously; after release fetch restarts at RESET_PC.
